// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, companion of the UART transmitter.
//
// The asynchronous RX line is synchronised through two flops. A falling edge
// of the synchronised line starts a frame. Each bit is sampled at mid-period
// using an oversampling tick derived from the system clock. Completed bytes
// are offered on a valid/acknowledge handshake.
//
// Parameters:
//   CLOCK_FREQUENCY  system clock frequency in Hz
//   BAUD_RATE        line bit rate
//   OVERSAMPLE       sample ticks per bit (even, >= 8)
//
// Ports:
//   Clk           in   system clock, rising edge
//   Reset         in   asynchronous active-low reset
//   RxWire        in   serial line, idle high, asynchronous to Clk
//   RxData        out  [7:0] last good received byte
//   RxValid       out  RxData holds an unacknowledged byte
//   RxAck         in   consumer acknowledge, clears RxValid
//   RxFrameError  out  one-cycle pulse: stop bit sampled low
//   RxOverrun     out  one-cycle pulse: unacknowledged byte overwritten
//   RxBusy        out  high while a frame is being received
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit is the 2-of-3 majority
//   of the samples at oversample counts OVERSAMPLE/2-1, OVERSAMPLE/2 and
//   OVERSAMPLE/2+1, decided at OVERSAMPLE/2+1. When undefined, a single
//   sample at OVERSAMPLE/2 is used.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLOCK_FREQUENCY = 1_000_000,
   parameter int BAUD_RATE       = 9600,
   parameter int OVERSAMPLE      = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       RxWire,
   output logic [7:0] RxData,
   output logic       RxValid,
   input  logic       RxAck,
   output logic       RxFrameError,
   output logic       RxOverrun,
   output logic       RxBusy
);

   localparam int DIVISOR_RAW = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
   localparam int DIVISOR     = (DIVISOR_RAW < 1) ? 1 : DIVISOR_RAW;
   localparam int DIV_W       = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam int OS_W        = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

   // A sample "at count N" is taken on the tick that advances the oversample
   // counter to N, i.e. while the counter still reads N-1. This places the
   // start-bit sample exactly half a bit after the detected edge.
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam logic [OS_W-1:0] OS_S0     = OS_W'(OVERSAMPLE/2 - 2);
   localparam logic [OS_W-1:0] OS_S1     = OS_W'(OVERSAMPLE/2 - 1);
   localparam logic [OS_W-1:0] OS_DECIDE = OS_W'(OVERSAMPLE/2);
`else
   localparam logic [OS_W-1:0] OS_DECIDE = OS_W'(OVERSAMPLE/2 - 1);
`endif

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_s_q, rx_s_d;
   logic             rx_prev_q, rx_prev_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [OS_W-1:0]  os_q, os_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
   logic             maj_a_q, maj_a_d;
   logic             maj_b_q, maj_b_d;
`endif

   logic fall;
   logic tick;
   logic decide;
   logic sample;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_prev_q   <= 1'b1;
         div_q       <= '0;
         os_q        <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
         maj_a_q     <= 1'b1;
         maj_b_q     <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_prev_q   <= rx_prev_d;
         div_q       <= div_d;
         os_q        <= os_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
         maj_a_q     <= maj_a_d;
         maj_b_q     <= maj_b_d;
`endif
      end
   end

   always_comb begin
      rx_meta_d   = RxWire;
      rx_s_d      = rx_meta_q;
      rx_prev_d   = rx_s_q;
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      fall = rx_prev_q & ~rx_s_q;
      tick = (div_q == DIV_LAST);

      // Free-running tick divider and oversample counter; both are
      // re-phased to the start edge below.
      if (tick) begin
         div_d = '0;
         os_d  = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
      end else begin
         div_d = div_q + 1'b1;
         os_d  = os_q;
      end

      decide = tick && (os_q == OS_DECIDE);

`ifdef UART_RX_MAJORITY_VOTE_EN
      maj_a_d = maj_a_q;
      maj_b_d = maj_b_q;
      if (tick && (os_q == OS_S0)) maj_a_d = rx_s_q;
      if (tick && (os_q == OS_S1)) maj_b_d = rx_s_q;
      sample = (maj_a_q & maj_b_q) | (maj_a_q & rx_s_q) | (maj_b_q & rx_s_q);
`else
      sample = rx_s_q;
`endif

      // Acknowledge only has an effect while a byte is pending.
      if (RxAck && valid_q) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall) begin
               state_d = START;
               div_d   = '0;
               os_d    = '0;
            end
         end
         START: begin
            if (decide) begin
               if (!sample) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;   // glitch shorter than half a bit
               end
            end
         end
         DATA: begin
            if (decide) begin
               shift_d[bit_idx_q] = sample;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (decide) begin
               if (sample) begin
                  data_d    = shift_q;
                  valid_d   = 1'b1;
                  // An acknowledge in the completion cycle consumes the old
                  // byte, so only an unacknowledged pending byte is lost.
                  overrun_d = valid_q & ~RxAck;
               end else begin
                  frame_err_d = 1'b1;
               end
               // Return to IDLE right away so a start edge that follows the
               // stop bit closely is still caught.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign RxData       = data_q;
   assign RxValid      = valid_q;
   assign RxFrameError = frame_err_q;
   assign RxOverrun    = overrun_q;
   assign RxBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// 1.536 MHz clock, 9600 baud, 16x oversampling: 10 clocks per tick and
// 160 clocks per bit. Expected bytes go into a scoreboard queue when a frame
// is driven and are compared whenever the receiver delivers a byte.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_F    = 1_536_000;
   localparam int BAUD     = 9600;
   localparam int OS       = 16;
   localparam int BIT_CLKS = 160;
`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int EXP_LAT  = 1533;
`else
   localparam int EXP_LAT  = 1523;
`endif

   logic       Clk;
   logic       Reset;
   logic       RxWire;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RxAck;
   logic       RxFrameError;
   logic       RxOverrun;
   logic       RxBusy;

   uart_rx #(
      .CLOCK_FREQUENCY (CLK_F),
      .BAUD_RATE       (BAUD),
      .OVERSAMPLE      (OS)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .RxWire       (RxWire),
      .RxData       (RxData),
      .RxValid      (RxValid),
      .RxAck        (RxAck),
      .RxFrameError (RxFrameError),
      .RxOverrun    (RxOverrun),
      .RxBusy       (RxBusy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int         vectors_applied = 0;
   int         miscompares     = 0;
   int         cyc             = 0;
   int         valid_rises     = 0;
   int         fe_pulses       = 0;
   int         or_pulses       = 0;
   int         valid_rise_cyc  = 0;
   int         fall_cyc        = 0;
   logic       valid_prev      = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge Clk) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: counts pulses and pops the scoreboard on every delivered
   // byte (a rising RxValid, or an overrun that replaced a pending byte).
   always @(negedge Clk) begin
      if (!Reset) begin
         valid_prev = 1'b0;
      end else begin
         if (RxFrameError) fe_pulses++;
         if (RxOverrun) or_pulses++;
         if ((RxValid && !valid_prev) || RxOverrun) begin
            if (RxValid && !valid_prev) begin
               valid_rises++;
               valid_rise_cyc = cyc;
            end
            if (exp_q.size() == 0) begin
               check_eq("sb_pending", exp_q.size(), 1);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check_eq("sb_rxdata", {24'h0, RxData}, {24'h0, e});
               $display("byte rx %02h exp %02h overrun=%0b", RxData, e, RxOverrun);
            end
         end
         valid_prev = RxValid;
      end
   end

   // Drives one frame; call at a falling clock edge. glitch_bit >= 0 inserts a
   // 10-clock low pulse around the middle of that data bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
      RxWire   = 1'b0;
      fall_cyc = cyc;
      repeat (BIT_CLKS) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         if (i == glitch_bit) begin
            RxWire = b[i];
            repeat (76) @(negedge Clk);
            RxWire = 1'b0;
            repeat (10) @(negedge Clk);
            RxWire = b[i];
            repeat (74) @(negedge Clk);
         end else begin
            RxWire = b[i];
            repeat (BIT_CLKS) @(negedge Clk);
         end
      end
      RxWire = stop_bit;
      repeat (BIT_CLKS) @(negedge Clk);
      RxWire = 1'b1;
      $display("frame tx %02h stop=%0b glitch_bit=%0d", b, stop_bit, glitch_bit);
   endtask

   task automatic ack_once();
      RxAck = 1'b1;
      @(negedge Clk);
      RxAck = 1'b0;
   endtask

   initial begin
      int lat;
      Reset  = 1'b0;
      RxWire = 1'b1;
      RxAck  = 1'b0;
      repeat (4) @(negedge Clk);
      check_eq("rst_data",  {24'h0, RxData}, 32'h00);
      check_eq("rst_valid", {31'h0, RxValid}, 32'h0);
      check_eq("rst_fe",    {31'h0, RxFrameError}, 32'h0);
      check_eq("rst_ovr",   {31'h0, RxOverrun}, 32'h0);
      check_eq("rst_busy",  {31'h0, RxBusy}, 32'h0);
      Reset = 1'b1;
      repeat (10) @(negedge Clk);

      // Frame with a low stop bit: one framing-error pulse, nothing delivered.
      send_frame(8'h55, 1'b0, -1);
      repeat (40) @(negedge Clk);
      check_eq("fe_pulses",   fe_pulses, 1);
      check_eq("fe_no_valid", valid_rises, 0);
      check_eq("fe_valid",    {31'h0, RxValid}, 32'h0);
      check_eq("fe_data",     {24'h0, RxData}, 32'h00);

      // Clean frame and its latency from the line's falling edge.
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1);
      repeat (40) @(negedge Clk);
      lat = valid_rise_cyc - fall_cyc;
      $display("latency %0d cycles (nominal %0d)", lat, EXP_LAT);
      check_eq("a5_latency_window", {31'h0, (lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)}, 32'h1);
      check_eq("a5_rises",  valid_rises, 1);
      check_eq("a5_fe",     fe_pulses, 1);
      check_eq("a5_ovr",    or_pulses, 0);
      check_eq("a5_valid",  {31'h0, RxValid}, 32'h1);
      check_eq("a5_data",   {24'h0, RxData}, 32'hA5);
      ack_once();
      check_eq("a5_ack_clears", {31'h0, RxValid}, 32'h0);

      // Back-to-back frames without acknowledge: second one overruns.
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      send_frame(8'h3C, 1'b1, -1);
      send_frame(8'hC3, 1'b1, -1);
      repeat (40) @(negedge Clk);
      check_eq("b2b_ovr",   or_pulses, 1);
      check_eq("b2b_rises", valid_rises, 2);
      check_eq("b2b_data",  {24'h0, RxData}, 32'hC3);
      check_eq("b2b_valid", {31'h0, RxValid}, 32'h1);
      ack_once();
      check_eq("b2b_ack_clears", {31'h0, RxValid}, 32'h0);

      // 40-clock low pulse: false start, receiver goes busy then back to idle.
      RxWire = 1'b0;
      repeat (20) @(negedge Clk);
      check_eq("glitch_busy_hi", {31'h0, RxBusy}, 32'h1);
      repeat (20) @(negedge Clk);
      RxWire = 1'b1;
      repeat (100) @(negedge Clk);
      check_eq("glitch_busy_lo", {31'h0, RxBusy}, 32'h0);
      check_eq("glitch_rises",   valid_rises, 2);
      check_eq("glitch_fe",      fe_pulses, 1);
      check_eq("glitch_ovr",     or_pulses, 1);
      check_eq("glitch_valid",   {31'h0, RxValid}, 32'h0);

      // Reset in the middle of data bit 4 of 8'hFF.
      RxWire = 1'b0;
      repeat (BIT_CLKS) @(negedge Clk);
      RxWire = 1'b1;
      repeat (4 * BIT_CLKS + 80) @(negedge Clk);
      check_eq("mid_busy", {31'h0, RxBusy}, 32'h1);
      Reset = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("mid_rst_data",  {24'h0, RxData}, 32'h00);
      check_eq("mid_rst_valid", {31'h0, RxValid}, 32'h0);
      check_eq("mid_rst_busy",  {31'h0, RxBusy}, 32'h0);
      check_eq("mid_rst_fe",    {31'h0, RxFrameError}, 32'h0);
      check_eq("mid_rst_ovr",   {31'h0, RxOverrun}, 32'h0);
      Reset = 1'b1;
      repeat (200) @(negedge Clk);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, -1);
      repeat (40) @(negedge Clk);
      check_eq("post_rst_valid", {31'h0, RxValid}, 32'h1);
      check_eq("post_rst_data",  {24'h0, RxData}, 32'h12);
      ack_once();

`ifdef UART_RX_MAJORITY_VOTE_EN
      // One of the three votes on data bit 2 is hit by a low glitch.
      repeat (20) @(negedge Clk);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b1, 2);
      repeat (40) @(negedge Clk);
      check_eq("vote_valid", {31'h0, RxValid}, 32'h1);
      check_eq("vote_data",  {24'h0, RxData}, 32'hFF);
`endif

      check_eq("sb_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
